// File: rtl/uart_echo_sequencer.sv
// Echo-path sequencer: captures received bytes into a small FIFO and feeds them to the UART transmitter.
// Optional build macro UART_ECHO_CRLF_EN appends 0x0A after every echoed 0x0D.
module uart_echo_sequencer #(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                clkIN,
    input  logic                resetIN,
    input  logic [7:0]          rxDataIN,
    input  logic                rxDoneIN,
    output logic                rxAckOUT,
    input  logic                txBusyIN,
    output logic [7:0]          txDataOUT,
    output logic                txStartOUT,
    output logic                overflowOUT,
    output logic [DEPTH_LOG2:0] levelOUT
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = DEPTH[DEPTH_LOG2:0];

`ifdef UART_ECHO_CRLF_EN
    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, LF} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
`endif

    state_t state, stateNext;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
    logic                  rxPrev;
    logic [1:0]            waitCnt;
    logic                  capture, push, pop, full, startNext;
    logic [7:0]            dataNext;
`ifdef UART_ECHO_CRLF_EN
    logic                  crSent;
`endif

    assign full    = (levelOUT == FULL_LEVEL);
    assign capture = rxDoneIN & ~rxPrev;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
    assign push    = capture & (~full | pop);

    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            state       <= IDLE;
            rxPrev      <= 1'b1;
            rxAckOUT    <= 1'b0;
            overflowOUT <= 1'b0;
            txStartOUT  <= 1'b0;
            txDataOUT   <= '0;
            waitCnt     <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            levelOUT    <= '0;
`ifdef UART_ECHO_CRLF_EN
            crSent      <= 1'b0;
`endif
        end else begin
            state      <= stateNext;
            rxPrev     <= rxDoneIN;
            txStartOUT <= startNext;
            txDataOUT  <= dataNext;
            if (startNext)
                waitCnt <= '0;
            else if (state == WAIT_BUSY)
                waitCnt <= waitCnt + 2'd1;
            if (capture)
                rxAckOUT <= 1'b1;
            else if (!rxDoneIN)
                rxAckOUT <= 1'b0;
            if (capture && !push)
                overflowOUT <= 1'b1;
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   levelOUT <= levelOUT + 1'b1;
                2'b01:   levelOUT <= levelOUT - 1'b1;
                default: ;
            endcase
`ifdef UART_ECHO_CRLF_EN
            if (pop)
                crSent <= (mem[rdPtr] == 8'h0D);
            else if (state == LF)
                crSent <= 1'b0;
`endif
        end
    end

    always_ff @(posedge clkIN) begin
        if (push)
            mem[wrPtr] <= rxDataIN;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:
                if (levelOUT != '0 && !txBusyIN)
                    stateNext = WAIT_BUSY;
            WAIT_BUSY:
                if (txBusyIN)
                    stateNext = WAIT_DONE;
                else if (waitCnt == 2'd3)
                    stateNext = IDLE;
            WAIT_DONE:
                if (!txBusyIN) begin
`ifdef UART_ECHO_CRLF_EN
                    stateNext = crSent ? LF : IDLE;
`else
                    stateNext = IDLE;
`endif
                end
`ifdef UART_ECHO_CRLF_EN
            LF:
                stateNext = WAIT_BUSY;
`endif
            default:
                stateNext = IDLE;
        endcase
    end

    always_comb begin
        pop       = (state == IDLE) && (levelOUT != '0) && !txBusyIN;
        startNext = pop;
        dataNext  = txDataOUT;
        if (pop)
            dataNext = mem[rdPtr];
`ifdef UART_ECHO_CRLF_EN
        if (state == LF) begin
            startNext = 1'b1;
            dataNext  = 8'h0A;
        end
`endif
    end

endmodule

// File: tb/tb_uart_echo_sequencer.sv
// Scoreboard bench for uart_echo_sequencer: a transmitter model consumes start pulses and checks echoed bytes in order.
module tb_uart_echo_sequencer;
    logic       clkIN = 1'b0;
    logic       resetIN = 1'b0;
    logic [7:0] rxDataIN = 8'h00;
    logic       rxDoneIN = 1'b0;
    logic       rxAckOUT;
    logic       txBusyIN;
    logic [7:0] txDataOUT;
    logic       txStartOUT;
    logic       overflowOUT;
    logic [2:0] levelOUT;

    int         total = 0;
    int         bad = 0;
    logic [7:0] expQ[$];
    int         startCyc[$];
    int         cycle = 0;
    int         busyLeft = 0;
    int         startCount = 0;
    bit         forceBusy = 1'b0;
    bit         respond = 1'b1;
    bit         prevStart = 1'b0;

    always #5 clkIN = ~clkIN;

    uart_echo_sequencer #(.DEPTH_LOG2(2)) dut (
        .clkIN(clkIN),
        .resetIN(resetIN),
        .rxDataIN(rxDataIN),
        .rxDoneIN(rxDoneIN),
        .rxAckOUT(rxAckOUT),
        .txBusyIN(txBusyIN),
        .txDataOUT(txDataOUT),
        .txStartOUT(txStartOUT),
        .overflowOUT(overflowOUT),
        .levelOUT(levelOUT)
    );

    // Transmitter model: busy for 10 cycles after each start unless respond is cleared.
    initial begin : txModel
        logic [7:0] e;
        txBusyIN = 1'b0;
        forever begin
            @(posedge clkIN);
            #2;
            cycle++;
            if (txStartOUT === 1'b1) begin
                startCount++;
                startCyc.push_back(cycle);
                total++;
                if (prevStart) begin
                    bad++;
                    $display("FAIL start_consecutive got=1 want=0 cycle=%0d", cycle);
                end
                total++;
                if (expQ.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected got=%02h want=none cycle=%0d", txDataOUT, cycle);
                end else begin
                    e = expQ.pop_front();
                    if (txDataOUT !== e) begin
                        bad++;
                        $display("FAIL sb_data got=%02h want=%02h cycle=%0d", txDataOUT, e, cycle);
                    end
                end
                if (respond)
                    busyLeft = 10;
            end else if (busyLeft > 0) begin
                busyLeft--;
            end
            prevStart = (txStartOUT === 1'b1);
            txBusyIN = forceBusy || (busyLeft > 0);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic doReset();
        @(negedge clkIN);
        resetIN = 1'b1;
        busyLeft = 0;
        forceBusy = 1'b0;
        respond = 1'b1;
        repeat (2) @(negedge clkIN);
        resetIN = 1'b0;
        expQ.delete();
    endtask

    task automatic sendRx(input logic [7:0] b, input int hi);
        @(negedge clkIN);
        rxDataIN = b;
        rxDoneIN = 1'b1;
        repeat (hi) @(negedge clkIN);
        rxDoneIN = 1'b0;
        repeat (2) @(negedge clkIN);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || txBusyIN) && n < 600) begin
            @(negedge clkIN);
            n++;
        end
        repeat (8) @(negedge clkIN);
    endtask

    task automatic test_reset();
        doReset();
        @(negedge clkIN);
        total++; if (txDataOUT !== 8'h00) begin bad++; $display("FAIL reset_txData got=%02h want=00", txDataOUT); end
        total++; if (txStartOUT !== 1'b0) begin bad++; $display("FAIL reset_txStart got=%b want=0", txStartOUT); end
        total++; if (rxAckOUT !== 1'b0) begin bad++; $display("FAIL reset_rxAck got=%b want=0", rxAckOUT); end
        total++; if (overflowOUT !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflowOUT); end
        total++; if (levelOUT !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", levelOUT); end
    endtask

    task automatic test_single();
        int s0;
        doReset();
        s0 = startCount;
        expQ.push_back(8'h41);
        @(negedge clkIN);
        rxDataIN = 8'h41;
        rxDoneIN = 1'b1;
        @(negedge clkIN);
        total++; if (rxAckOUT !== 1'b1) begin bad++; $display("FAIL single_ack_rise got=%b want=1", rxAckOUT); end
        total++; if (levelOUT !== 3'd1) begin bad++; $display("FAIL single_level1 got=%0d want=1", levelOUT); end
        total++; if (txStartOUT !== 1'b0) begin bad++; $display("FAIL single_start_early got=%b want=0", txStartOUT); end
        @(negedge clkIN);
        total++; if (txStartOUT !== 1'b1) begin bad++; $display("FAIL single_start got=%b want=1", txStartOUT); end
        total++; if (txDataOUT !== 8'h41) begin bad++; $display("FAIL single_data got=%02h want=41", txDataOUT); end
        total++; if (levelOUT !== 3'd0) begin bad++; $display("FAIL single_level0 got=%0d want=0", levelOUT); end
        @(negedge clkIN);
        rxDoneIN = 1'b0;
        total++; if (txStartOUT !== 1'b0) begin bad++; $display("FAIL single_start_once got=%b want=0", txStartOUT); end
        total++; if (rxAckOUT !== 1'b1) begin bad++; $display("FAIL single_ack_hold got=%b want=1", rxAckOUT); end
        @(negedge clkIN);
        total++; if (rxAckOUT !== 1'b0) begin bad++; $display("FAIL single_ack_fall got=%b want=0", rxAckOUT); end
        drain();
        total++; if (startCount - s0 != 1) begin bad++; $display("FAIL single_starts got=%0d want=1", startCount - s0); end
        total++; if (txDataOUT !== 8'h41) begin bad++; $display("FAIL single_data_stable got=%02h want=41", txDataOUT); end
        total++; if (overflowOUT !== 1'b0) begin bad++; $display("FAIL single_overflow got=%b want=0", overflowOUT); end
    endtask

    task automatic test_burst();
        logic [2:0] wantLvl;
        doReset();
        forceBusy = 1'b1;
        repeat (3) @(negedge clkIN);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4)
                expQ.push_back(8'(i));
            sendRx(8'(i), 2);
            wantLvl = (i <= 4) ? 3'(i) : 3'd4;
            total++; if (levelOUT !== wantLvl) begin bad++; $display("FAIL burst_level%0d got=%0d want=%0d", i, levelOUT, wantLvl); end
            total++; if (overflowOUT !== (i == 5)) begin bad++; $display("FAIL burst_ovf%0d got=%b want=%b", i, overflowOUT, (i == 5)); end
        end
        forceBusy = 1'b0;
        drain();
        total++; if (expQ.size() != 0) begin bad++; $display("FAIL burst_drain got=%0d want=0", expQ.size()); end
        total++; if (overflowOUT !== 1'b1) begin bad++; $display("FAIL burst_ovf_sticky got=%b want=1", overflowOUT); end
        total++; if (levelOUT !== 3'd0) begin bad++; $display("FAIL burst_level_end got=%0d want=0", levelOUT); end
    endtask

    task automatic test_full_pop();
        doReset();
        forceBusy = 1'b1;
        repeat (3) @(negedge clkIN);
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(8'h11 + 8'(i));
            sendRx(8'h11 + 8'(i), 2);
        end
        total++; if (levelOUT !== 3'd4) begin bad++; $display("FAIL fullpop_full got=%0d want=4", levelOUT); end
        @(negedge clkIN);
        forceBusy = 1'b0;
        @(negedge clkIN);
        rxDataIN = 8'h15;
        rxDoneIN = 1'b1;
        expQ.push_back(8'h15);
        @(negedge clkIN);
        total++; if (levelOUT !== 3'd4) begin bad++; $display("FAIL fullpop_level got=%0d want=4", levelOUT); end
        total++; if (overflowOUT !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%b want=0", overflowOUT); end
        total++; if (txStartOUT !== 1'b1) begin bad++; $display("FAIL fullpop_start got=%b want=1", txStartOUT); end
        rxDoneIN = 1'b0;
        drain();
        total++; if (expQ.size() != 0) begin bad++; $display("FAIL fullpop_drain got=%0d want=0", expQ.size()); end
        total++; if (overflowOUT !== 1'b0) begin bad++; $display("FAIL fullpop_ovf_end got=%b want=0", overflowOUT); end
    endtask

    task automatic test_timeout();
        int n0;
        int n;
        doReset();
        forceBusy = 1'b1;
        respond = 1'b0;
        repeat (3) @(negedge clkIN);
        expQ.push_back(8'hA1);
        sendRx(8'hA1, 2);
        expQ.push_back(8'hA2);
        sendRx(8'hA2, 2);
        n0 = startCyc.size();
        forceBusy = 1'b0;
        n = 0;
        while (startCyc.size() < n0 + 2 && n < 60) begin
            @(negedge clkIN);
            n++;
        end
        total++;
        if (startCyc.size() < n0 + 2) begin
            bad++;
            $display("FAIL timeout_starts got=%0d want=2", startCyc.size() - n0);
        end else begin
            total++;
            if (startCyc[n0 + 1] - startCyc[n0] != 5) begin
                bad++;
                $display("FAIL timeout_gap got=%0d want=5", startCyc[n0 + 1] - startCyc[n0]);
            end
        end
        drain();
        total++; if (expQ.size() != 0) begin bad++; $display("FAIL timeout_drain got=%0d want=0", expQ.size()); end
    endtask

    task automatic test_crlf();
        int s0;
        int want;
        doReset();
        s0 = startCount;
        expQ.push_back(8'h0D);
`ifdef UART_ECHO_CRLF_EN
        expQ.push_back(8'h0A);
        want = 3;
`else
        want = 2;
`endif
        expQ.push_back(8'h55);
        sendRx(8'h0D, 2);
        sendRx(8'h55, 2);
        drain();
        total++; if (startCount - s0 != want) begin bad++; $display("FAIL crlf_starts got=%0d want=%0d", startCount - s0, want); end
        total++; if (expQ.size() != 0) begin bad++; $display("FAIL crlf_drain got=%0d want=0", expQ.size()); end
        total++; if (txDataOUT !== 8'h55) begin bad++; $display("FAIL crlf_last got=%02h want=55", txDataOUT); end
    endtask

    task automatic test_reset_hold();
        int s0;
        @(negedge clkIN);
        rxDataIN = 8'h77;
        rxDoneIN = 1'b1;
        resetIN = 1'b1;
        busyLeft = 0;
        respond = 1'b1;
        forceBusy = 1'b0;
        repeat (2) @(negedge clkIN);
        resetIN = 1'b0;
        expQ.delete();
        repeat (4) @(negedge clkIN);
        total++; if (levelOUT !== 3'd0) begin bad++; $display("FAIL hold_level got=%0d want=0", levelOUT); end
        total++; if (rxAckOUT !== 1'b0) begin bad++; $display("FAIL hold_ack got=%b want=0", rxAckOUT); end
        total++; if (txStartOUT !== 1'b0) begin bad++; $display("FAIL hold_start got=%b want=0", txStartOUT); end
        rxDoneIN = 1'b0;
        repeat (2) @(negedge clkIN);
        expQ.push_back(8'h61);
        sendRx(8'h61, 2);
        sendRx(8'h62, 2);
        total++; if (levelOUT !== 3'd1) begin bad++; $display("FAIL midrst_level_pre got=%0d want=1", levelOUT); end
        resetIN = 1'b1;
        @(negedge clkIN);
        total++; if (txDataOUT !== 8'h00) begin bad++; $display("FAIL midrst_txData got=%02h want=00", txDataOUT); end
        total++; if (txStartOUT !== 1'b0) begin bad++; $display("FAIL midrst_start got=%b want=0", txStartOUT); end
        total++; if (rxAckOUT !== 1'b0) begin bad++; $display("FAIL midrst_ack got=%b want=0", rxAckOUT); end
        total++; if (overflowOUT !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b want=0", overflowOUT); end
        total++; if (levelOUT !== 3'd0) begin bad++; $display("FAIL midrst_level got=%0d want=0", levelOUT); end
        resetIN = 1'b0;
        expQ.delete();
        s0 = startCount;
        repeat (20) @(negedge clkIN);
        total++; if (startCount != s0) begin bad++; $display("FAIL midrst_no_start got=%0d want=0", startCount - s0); end
    endtask

    initial begin : main
        test_reset();
        test_single();
        test_burst();
        test_full_pop();
        test_timeout();
        test_crlf();
        test_reset_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
